// File: rtl/pkfb_multich_fifo_if.sv
// rtl/pkfb_multich_fifo_if.sv - push/pop/status bundle for the multichannel packet FIFO
interface pkfb_multich_fifo_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]       FB_PKfbData;
    logic [NUM_CH-1:0]       FB_PKfbPush;
    logic                    FB_PKfbSOF;
    logic                    FB_PKfbEOF;
    logic [NUM_CH-1:0]       FB_PKfbOverflow;
    logic [NUM_CH-1:0]       Ovf_Clr;
    logic [CH_W-1:0]         Rd_Ch;
    logic                    Rd_Pop;
    logic [DATA_W-1:0]       Rd_Data;
    logic                    Rd_SOF;
    logic                    Rd_EOF;
    logic                    Rd_Vld;
    logic [NUM_CH-1:0]       Ch_Empty;
    logic [NUM_CH*LVL_W-1:0] Ch_Level;

    modport master (
        output FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Ch, Rd_Pop,
        input  FB_PKfbOverflow, Rd_Data, Rd_SOF, Rd_EOF, Rd_Vld, Ch_Empty, Ch_Level
    );

    modport slave (
        input  FB_PKfbData, FB_PKfbPush, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Ch, Rd_Pop,
        output FB_PKfbOverflow, Rd_Data, Rd_SOF, Rd_EOF, Rd_Vld, Ch_Empty, Ch_Level
    );
endinterface

// File: rtl/pkfb_multich_fifo.sv
// rtl/pkfb_multich_fifo.sv - NUM_CH packet FIFOs with sticky overflow and drop-to-next-SOF recovery
module pkfb_multich_fifo #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int DROP_MODE = 1
) (
    input  logic                WB_CLK,
    input  logic                WB_RST,
    pkfb_multich_fifo_if.slave  fb
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WRD_W = DATA_W + 2;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } ch_state_t;

    logic [NUM_CH-1:0]            pop_ok;
    logic [NUM_CH-1:0][WRD_W-1:0] head_word;
    logic [WRD_W-1:0]             rd_word_d;
    logic [WRD_W-1:0]             rd_word_q;
    logic                         rd_vld_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t         st_q, st_d;
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [LVL_W-1:0]  level_q;
        logic              ovf_q;
        logic              wr_en, ovf_set, full, push;
        logic [WRD_W-1:0]  mem [DEPTH];

        assign push      = fb.FB_PKfbPush[i];
        assign full      = (level_q == LVL_W'(DEPTH));
        // Pop looks only at pre-edge level, so an empty channel never falls through a same-cycle push.
        assign pop_ok[i] = fb.Rd_Pop && (fb.Rd_Ch == CH_W'(i)) && (level_q != '0);

        always_comb begin
            wr_en   = 1'b0;
            ovf_set = 1'b0;
            st_d    = st_q;
            if (push) begin
                unique case (st_q)
                    PASS: begin
                        if (!full) begin
                            wr_en = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                            if ((DROP_MODE != 0) && !fb.FB_PKfbEOF) begin
                                st_d = DROP;
                            end
                        end
                    end
                    DROP: begin
                        if (fb.FB_PKfbSOF) begin
                            if (!full) begin
                                wr_en = 1'b1;
                                st_d  = PASS;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end else if (fb.FB_PKfbEOF) begin
                            st_d = PASS;
                        end
                    end
                    default: st_d = PASS;
                endcase
            end
        end

        always_ff @(posedge WB_CLK or posedge WB_RST) begin
            if (WB_RST) begin
                st_q     <= PASS;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                st_q <= st_d;
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_ok[i]) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop_ok[i]);
                // A fresh overflow beats a simultaneous clear so no event is lost.
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end else if (fb.Ovf_Clr[i]) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        always_ff @(posedge WB_CLK) begin
            if (wr_en) begin
                mem[wr_ptr_q] <= {fb.FB_PKfbEOF, fb.FB_PKfbSOF, fb.FB_PKfbData};
            end
        end

        assign head_word[i]                       = mem[rd_ptr_q];
        assign fb.FB_PKfbOverflow[i]              = ovf_q;
        assign fb.Ch_Empty[i]                     = (level_q == '0);
        assign fb.Ch_Level[i*LVL_W +: LVL_W]      = level_q;
    end

    always_comb begin
        rd_word_d = rd_word_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_ok[c]) begin
                rd_word_d = head_word[c];
            end
        end
    end

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            rd_vld_q  <= 1'b0;
            rd_word_q <= '0;
        end else begin
            rd_vld_q  <= |pop_ok;
            rd_word_q <= rd_word_d;
        end
    end

    assign fb.Rd_Data = rd_word_q[DATA_W-1:0];
    assign fb.Rd_SOF  = rd_word_q[DATA_W];
    assign fb.Rd_EOF  = rd_word_q[DATA_W+1];
    assign fb.Rd_Vld  = rd_vld_q;
endmodule

// File: tb/tb_pkfb_multich_fifo.sv
// tb/tb_pkfb_multich_fifo.sv - scoreboard bench driving a DROP_MODE=1 and a DROP_MODE=0 instance in lockstep
module tb_pkfb_multich_fifo;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = 5;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] data_r  = '0;
    logic [3:0]  push_r  = '0;
    logic [3:0]  clr_r   = '0;
    logic        sof_r   = 1'b0;
    logic        eof_r   = 1'b0;
    logic [1:0]  rd_ch_r = '0;
    logic        rd_pop_r = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp0_q[$];
    logic [33:0] got_w, want_w;

    always #5 wb_clk = ~wb_clk;

    pkfb_multich_fifo_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    pkfb_multich_fifo_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();

    assign bus.FB_PKfbData  = data_r;   assign bus0.FB_PKfbData  = data_r;
    assign bus.FB_PKfbPush  = push_r;   assign bus0.FB_PKfbPush  = push_r;
    assign bus.FB_PKfbSOF   = sof_r;    assign bus0.FB_PKfbSOF   = sof_r;
    assign bus.FB_PKfbEOF   = eof_r;    assign bus0.FB_PKfbEOF   = eof_r;
    assign bus.Ovf_Clr      = clr_r;    assign bus0.Ovf_Clr      = clr_r;
    assign bus.Rd_Ch        = rd_ch_r;  assign bus0.Rd_Ch        = rd_ch_r;
    assign bus.Rd_Pop       = rd_pop_r; assign bus0.Rd_Pop       = rd_pop_r;

    pkfb_multich_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_MODE(1)) dut (
        .WB_CLK (wb_clk),
        .WB_RST (wb_rst),
        .fb     (bus)
    );

    pkfb_multich_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_MODE(0)) dut0 (
        .WB_CLK (wb_clk),
        .WB_RST (wb_rst),
        .fb     (bus0)
    );

    always @(negedge wb_clk) begin
        if (bus.Rd_Vld) begin
            n_total++;
            got_w = {bus.Rd_EOF, bus.Rd_SOF, bus.Rd_Data};
            if (exp_q.size() == 0) begin
                $display("FAIL rd_word_drop1: got %h expected no pop", got_w);
            end else begin
                want_w = exp_q.pop_front();
                if (got_w === want_w) n_pass++;
                else $display("FAIL rd_word_drop1: got %h expected %h", got_w, want_w);
            end
        end
        if (bus0.Rd_Vld) begin
            n_total++;
            got_w = {bus0.Rd_EOF, bus0.Rd_SOF, bus0.Rd_Data};
            if (exp0_q.size() == 0) begin
                $display("FAIL rd_word_drop0: got %h expected no pop", got_w);
            end else begin
                want_w = exp0_q.pop_front();
                if (got_w === want_w) n_pass++;
                else $display("FAIL rd_word_drop0: got %h expected %h", got_w, want_w);
            end
        end
    end

    function automatic logic [33:0] mk(input logic [31:0] d, input logic s, input logic e);
        return {e, s, d};
    endfunction

    function automatic logic [4:0] lvl(input logic [NUM_CH*LVL_W-1:0] v, input int ch);
        return v[ch*LVL_W +: LVL_W];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic push_cyc(input logic [3:0] m, input logic [31:0] d, input logic s, input logic e);
        push_r = m; data_r = d; sof_r = s; eof_r = e;
        cyc();
        push_r = '0; sof_r = 1'b0; eof_r = 1'b0;
    endtask

    task automatic pop_cyc(input int ch, input logic [33:0] e1, input logic [33:0] e0);
        rd_ch_r = 2'(ch); rd_pop_r = 1'b1;
        exp_q.push_back(e1);
        exp0_q.push_back(e0);
        cyc();
        rd_pop_r = 1'b0;
    endtask

    task automatic chk_rst(input string sfx);
        chk({"rst_level_d1", sfx}, 64'(bus.Ch_Level), 64'(0));
        chk({"rst_level_d0", sfx}, 64'(bus0.Ch_Level), 64'(0));
        chk({"rst_empty", sfx}, 64'({bus.Ch_Empty, bus0.Ch_Empty}), 64'hFF);
        chk({"rst_ovf", sfx}, 64'({bus.FB_PKfbOverflow, bus0.FB_PKfbOverflow}), 64'(0));
        chk({"rst_rd", sfx}, 64'({bus.Rd_Vld, bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data}), 64'(0));
    endtask

    initial begin
        repeat (2) @(posedge wb_clk);
        #1;
        chk_rst("_init");
        wb_rst = 1'b0;
        cyc();

        // 1: four-word packet through channel 0
        for (int k = 0; k < 4; k++) push_cyc(4'b0001, 32'hA000_0000 + k, k == 0, k == 3);
        chk("t1_level4", 64'({lvl(bus.Ch_Level, 0), lvl(bus0.Ch_Level, 0)}), 64'({5'd4, 5'd4}));
        for (int k = 0; k < 4; k++) begin
            pop_cyc(0, mk(32'hA000_0000 + k, k == 0, k == 3), mk(32'hA000_0000 + k, k == 0, k == 3));
            chk("t1_level_dn", 64'(lvl(bus.Ch_Level, 0)), 64'(3 - k));
        end
        chk("t1_empty", 64'({bus.Ch_Empty[0], bus0.Ch_Empty[0]}), 64'b11);

        // 2/3: overflow on channel 1, drop vs. no-drop recovery
        for (int k = 0; k < 16; k++) push_cyc(4'b0010, 32'h1000_0000 + k, k == 0, 1'b0);
        chk("t2_full", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd16, 5'd16}));
        push_cyc(4'b0010, 32'h1111_0011, 1'b0, 1'b0);
        chk("t2_ovf", 64'({bus.FB_PKfbOverflow, bus0.FB_PKfbOverflow}), 64'h22);
        chk("t2_lvl_ovf", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd16, 5'd16}));
        for (int k = 0; k < 3; k++) push_cyc(4'b0010, 32'h1200_0000 + k, 1'b0, 1'b0);
        chk("t2_lvl_disc", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd16, 5'd16}));
        pop_cyc(1, mk(32'h1000_0000, 1'b1, 1'b0), mk(32'h1000_0000, 1'b1, 1'b0));
        chk("t2_lvl_pop", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd15, 5'd15}));
        push_cyc(4'b0010, 32'h1300_0000, 1'b0, 1'b0);
        chk("t3_plain_push", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd15, 5'd16}));
        push_cyc(4'b0010, 32'h1400_0000, 1'b1, 1'b0);
        chk("t2_sof_push", 64'({lvl(bus.Ch_Level, 1), lvl(bus0.Ch_Level, 1)}), 64'({5'd16, 5'd16}));
        for (int k = 1; k < 16; k++) pop_cyc(1, mk(32'h1000_0000 + k, 1'b0, 1'b0), mk(32'h1000_0000 + k, 1'b0, 1'b0));
        pop_cyc(1, mk(32'h1400_0000, 1'b1, 1'b0), mk(32'h1300_0000, 1'b0, 1'b0));
        chk("t2_drained", 64'({bus.Ch_Empty[1], bus0.Ch_Empty[1]}), 64'b11);

        // 4: same-cycle push+pop on a full channel and on an empty one
        for (int k = 0; k < 16; k++) push_cyc(4'b0100, 32'h2000_0000 + k, 1'b0, 1'b0);
        push_r = 4'b0100; data_r = 32'h2FFF_FFFF; rd_ch_r = 2'd2; rd_pop_r = 1'b1;
        exp_q.push_back(mk(32'h2000_0000, 1'b0, 1'b0));
        exp0_q.push_back(mk(32'h2000_0000, 1'b0, 1'b0));
        cyc();
        push_r = '0; rd_pop_r = 1'b0;
        chk("t4_full_ovf", 64'({bus.FB_PKfbOverflow[2], bus0.FB_PKfbOverflow[2]}), 64'b11);
        chk("t4_full_lvl", 64'({lvl(bus.Ch_Level, 2), lvl(bus0.Ch_Level, 2)}), 64'({5'd15, 5'd15}));
        push_r = 4'b1000; data_r = 32'h3000_0000; sof_r = 1'b1; eof_r = 1'b1; rd_ch_r = 2'd3; rd_pop_r = 1'b1;
        cyc();
        push_r = '0; sof_r = 1'b0; eof_r = 1'b0; rd_pop_r = 1'b0;
        chk("t4_empty_novld", 64'({bus.Rd_Vld, bus0.Rd_Vld}), 64'b00);
        chk("t4_empty_lvl", 64'({lvl(bus.Ch_Level, 3), lvl(bus0.Ch_Level, 3)}), 64'({5'd1, 5'd1}));
        for (int k = 1; k < 16; k++) pop_cyc(2, mk(32'h2000_0000 + k, 1'b0, 1'b0), mk(32'h2000_0000 + k, 1'b0, 1'b0));
        pop_cyc(3, mk(32'h3000_0000, 1'b1, 1'b1), mk(32'h3000_0000, 1'b1, 1'b1));
        chk("t4_all_empty", 64'({bus.Ch_Empty, bus0.Ch_Empty}), 64'hFF);

        // 5: broadcast push to all channels
        push_cyc(4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("t5_lvl_d1", 64'(bus.Ch_Level), 64'h08421);
        chk("t5_lvl_d0", 64'(bus0.Ch_Level), 64'h08421);
        for (int c = 0; c < 4; c++) pop_cyc(c, mk(32'hDEAD_BEEF, 1'b1, 1'b1), mk(32'hDEAD_BEEF, 1'b1, 1'b1));
        rd_ch_r = 2'd0; rd_pop_r = 1'b1;
        cyc();
        rd_pop_r = 1'b0;
        chk("t5_pop_empty", 64'({bus.Rd_Vld, bus.Rd_Data}), 64'({1'b0, 32'hDEAD_BEEF}));

        // 6: clear-vs-set priority, then asynchronous reset mid-packet
        clr_r = 4'b0010;
        cyc();
        clr_r = '0;
        chk("t6_clr1", 64'({bus.FB_PKfbOverflow, bus0.FB_PKfbOverflow}), 64'h44);
        for (int k = 0; k < 16; k++) push_cyc(4'b0010, 32'h6000_0000 + k, k == 0, 1'b0);
        push_r = 4'b0010; data_r = 32'h6666_6666; clr_r = 4'b0010;
        cyc();
        push_r = '0; clr_r = '0;
        chk("t6_set_wins", 64'({bus.FB_PKfbOverflow, bus0.FB_PKfbOverflow}), 64'h66);
        clr_r = 4'b0010;
        cyc();
        clr_r = '0;
        chk("t6_clr_alone", 64'({bus.FB_PKfbOverflow, bus0.FB_PKfbOverflow}), 64'h44);
        push_r = 4'b0001; data_r = 32'h7000_0000; sof_r = 1'b1; rd_ch_r = 2'd1; rd_pop_r = 1'b1;
        exp_q.push_back(mk(32'h6000_0000, 1'b1, 1'b0));
        exp0_q.push_back(mk(32'h6000_0000, 1'b1, 1'b0));
        cyc();
        push_r = '0; sof_r = 1'b0; rd_pop_r = 1'b0;
        #6;
        wb_rst = 1'b1;
        #1;
        chk_rst("_async");
        cyc();
        wb_rst = 1'b0;
        cyc();
        chk("queues_drained", 64'({exp_q.size(), exp0_q.size()}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
